// File: rtl/state_dump_unit_pkg.sv
// Shared types and widths for the post-halt state dump engine.
package state_dump_unit_pkg;

  localparam int WORD_W = 32;
  localparam int RF_AW  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REGS = 2'd1,
    MEM  = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/dump_checksum.sv
// Running mod-2^32 sum of every accepted dump beat.
module dump_checksum
  import state_dump_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] sum_o
);

  logic [WORD_W-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
    end else if (enable_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/state_dump_unit.sv
// Streams the register file and then data memory out over valid/ready once the CPU halts.
module state_dump_unit
  import state_dump_unit_pkg::*;
#(
  parameter int                NUM_REGS  = 32,
  parameter int                MEM_WORDS = 1024,
  parameter logic [WORD_W-1:0] MEM_BASE  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  output logic [RF_AW-1:0]  rf_raddr,
  input  logic [WORD_W-1:0] rf_rdata,
  output logic [WORD_W-1:0] dmem_raddr,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_is_mem,
  output logic [WORD_W-1:0] out_index,
  output logic              out_last,
  output logic              done,
  output logic [WORD_W-1:0] checksum
);

  dump_state_t       state_q;
  logic [WORD_W-1:0] fptr_q;
  logic              out_valid_q;
  logic [WORD_W-1:0] out_data_q;
  logic              out_is_mem_q;
  logic [WORD_W-1:0] out_index_q;
  logic              out_last_q;
  logic              done_q;
  logic              handshake;

  assign handshake = out_valid_q & out_ready;

  // While the last register beat is pending, fptr equals NUM_REGS and the
  // memory port already presents word 0, so the section switch has no bubble.
  assign rf_raddr   = fptr_q[RF_AW-1:0];
  assign dmem_raddr = (state_q == MEM) ? MEM_BASE + {fptr_q[WORD_W-3:0], 2'b00} : MEM_BASE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fptr_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_is_mem_q <= 1'b0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (halt) begin
            state_q      <= REGS;
            out_valid_q  <= 1'b1;
            out_data_q   <= '0;
            out_is_mem_q <= 1'b0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            fptr_q       <= 32'd1;
          end
        end
        REGS: begin
          if (handshake) begin
            if (fptr_q == 32'(NUM_REGS)) begin
              state_q      <= MEM;
              out_data_q   <= dmem_rdata;
              out_is_mem_q <= 1'b1;
              out_index_q  <= '0;
              out_last_q   <= (MEM_WORDS == 1);
              fptr_q       <= 32'd1;
            end else begin
              out_data_q  <= rf_rdata;
              out_index_q <= fptr_q;
              fptr_q      <= fptr_q + 32'd1;
            end
          end
        end
        MEM: begin
          if (handshake) begin
            if (out_last_q) begin
              state_q     <= DONE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_data_q  <= dmem_rdata;
              out_index_q <= fptr_q;
              out_last_q  <= (fptr_q == 32'(MEM_WORDS - 1));
              fptr_q      <= fptr_q + 32'd1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  dump_checksum u_checksum (
    .clk      (clk),
    .rst      (rst),
    .clear_i  ((state_q == IDLE) && halt),
    .enable_i (handshake),
    .data_i   (out_data_q),
    .sum_o    (checksum)
  );

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_is_mem = out_is_mem_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// Self-checking bench for state_dump_unit: a 32-reg/8-word instance plus a 4/4 instance for checksum wrap.
module tb_state_dump_unit;

  localparam int          NREGS  = 32;
  localparam int          NMEM   = 8;
  localparam int          TOTAL  = NREGS + NMEM;
  localparam int          BUDGET = TOTAL * 4 + 20;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] SBASE  = 32'h0000_0040;

  typedef struct packed {
    logic [31:0] data;
    logic        isMem;
    logic [31:0] index;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  rfAddr;
  logic [31:0] rfData, dmemAddr, dmemData, memOff;
  logic        outValid, outIsMem, outLast, done;
  logic [31:0] outData, outIndex, checksum;

  logic        sHalt = 1'b0;
  logic        sReady = 1'b0;
  logic [4:0]  sRfAddr;
  logic [31:0] sRfData, sDmemAddr, sDmemData, sData, sIndex, sChecksum;
  logic        sValid, sIsMem, sLast, sDone;

  logic [31:0] rfModel  [NREGS];
  logic [31:0] memModel [NMEM];
  beat_t       expQ[$];
  logic [31:0] expSum;
  int          nAssert = 0;
  int          nFail   = 0;

  always #5 clk = ~clk;

  assign memOff = dmemAddr - BASE;
  always_comb begin
    rfData   = rfModel[rfAddr];
    dmemData = 32'hBAD0_BAD0;
    if (dmemAddr[1:0] == 2'b00 && dmemAddr >= BASE && memOff < 32'(NMEM * 4))
      dmemData = memModel[memOff[4:2]];
  end

  assign sRfData   = (sRfAddr < 5'd4) ? 32'hFFFF_FFFF : 32'h0;
  assign sDmemData = (sDmemAddr >= SBASE && sDmemAddr < SBASE + 32'd16) ? 32'hFFFF_FFFF : 32'h0;

  state_dump_unit #(.NUM_REGS(NREGS), .MEM_WORDS(NMEM), .MEM_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .rf_raddr(rfAddr), .rf_rdata(rfData),
    .dmem_raddr(dmemAddr), .dmem_rdata(dmemData),
    .out_valid(outValid), .out_ready(out_ready), .out_data(outData),
    .out_is_mem(outIsMem), .out_index(outIndex), .out_last(outLast),
    .done(done), .checksum(checksum)
  );

  state_dump_unit #(.NUM_REGS(4), .MEM_WORDS(4), .MEM_BASE(SBASE)) dutSmall (
    .clk(clk), .rst(rst), .halt(sHalt),
    .rf_raddr(sRfAddr), .rf_rdata(sRfData),
    .dmem_raddr(sDmemAddr), .dmem_rdata(sDmemData),
    .out_valid(sValid), .out_ready(sReady), .out_data(sData),
    .out_is_mem(sIsMem), .out_index(sIndex), .out_last(sLast),
    .done(sDone), .checksum(sChecksum)
  );

  // Expected beat stream: registers (x0 forced to zero) then memory, last flag on the final word.
  task automatic build_model();
    beat_t b;
    expQ.delete();
    expSum = 32'h0;
    for (int i = 0; i < NREGS; i++) begin
      b.data = (i == 0) ? 32'h0 : rfModel[i];
      b.isMem = 1'b0; b.index = 32'(i); b.last = 1'b0;
      expQ.push_back(b);
      expSum += b.data;
    end
    for (int k = 0; k < NMEM; k++) begin
      b.data = memModel[k];
      b.isMem = 1'b1; b.index = 32'(k); b.last = (k == NMEM - 1);
      expQ.push_back(b);
      expSum += b.data;
    end
  endtask

  task automatic preload_pattern();
    for (int i = 0; i < NREGS; i++) rfModel[i] = 32'(i) * 32'h11;
    rfModel[0] = 32'hDEAD_BEEF;
    for (int k = 0; k < NMEM; k++) memModel[k] = 32'hA000_0000 + 32'(k);
    build_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    halt = 1'b0; sHalt = 1'b0; out_ready = 1'b0; sReady = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raises halt at a falling edge and consumes the stream; readyMode 0=always, 1=1,0,0,1 pattern, 2=random.
  task automatic stream_dump(input int readyMode, input bit keepHalt, input int abortBeat, input string tag);
    int          beats = 0;
    int          cycles = 0;
    bit          stalled = 1'b0;
    bit          r;
    logic [31:0] hData, hIndex;
    logic        hMem, hLast;
    out_ready = 1'b0;
    halt = 1'b1;
    @(negedge clk);
    if (!keepHalt) halt = 1'b0;
    while (beats < TOTAL && cycles < BUDGET) begin
      if (beats == abortBeat) return;
      nAssert++;
      if (outValid !== 1'b1 || done !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL %s valid/done beat %0d: got valid=%b done=%b, want valid=1 done=0", tag, beats, outValid, done);
      end
      if (stalled) begin
        nAssert++;
        if ({outData, outIndex, outIsMem, outLast} !== {hData, hIndex, hMem, hLast}) begin
          nFail++;
          $display("[TB] FAIL %s hold beat %0d: got data=%h idx=%0d, want data=%h idx=%0d", tag, beats, outData, outIndex, hData, hIndex);
        end
      end
      nAssert++;
      if (outData !== expQ[beats].data || outIndex !== expQ[beats].index ||
          outIsMem !== expQ[beats].isMem || outLast !== expQ[beats].last) begin
        nFail++;
        $display("[TB] FAIL %s beat %0d: got data=%h idx=%0d mem=%b last=%b, want data=%h idx=%0d mem=%b last=%b",
                 tag, beats, outData, outIndex, outIsMem, outLast,
                 expQ[beats].data, expQ[beats].index, expQ[beats].isMem, expQ[beats].last);
      end
      case (readyMode)
        0:       r = 1'b1;
        1:       r = (cycles % 4 == 0) || (cycles % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      hData = outData; hIndex = outIndex; hMem = outIsMem; hLast = outLast;
      stalled = !r;
      if (r && outValid === 1'b1) beats++;
      cycles++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    nAssert++;
    if (beats != TOTAL) begin
      nFail++;
      $display("[TB] FAIL %s timeout: got %0d beats in %0d cycles, want %0d", tag, beats, cycles, TOTAL);
    end
    nAssert++;
    if (done !== 1'b1 || outValid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL %s done: got done=%b valid=%b, want done=1 valid=0", tag, done, outValid);
    end
    nAssert++;
    if (checksum !== expSum) begin
      nFail++;
      $display("[TB] FAIL %s checksum: got %h, want %h", tag, checksum, expSum);
    end
  endtask

  task automatic test_reset();
    preload_pattern();
    do_reset();
    stream_dump(0, 1'b1, 5, "reset_pre");
    #2 rst = 1'b1;
    #1;
    nAssert++;
    if ({outValid, outData, outIsMem, outIndex, outLast, done} !== {1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      nFail++;
      $display("[TB] FAIL reset outputs: got valid=%b data=%h mem=%b idx=%0d last=%b done=%b, want all 0",
               outValid, outData, outIsMem, outIndex, outLast, done);
    end
    nAssert++;
    if (checksum !== 32'h0) begin
      nFail++;
      $display("[TB] FAIL reset checksum: got %h, want 0", checksum);
    end
    nAssert++;
    if (rfAddr !== 5'd0 || dmemAddr !== BASE) begin
      nFail++;
      $display("[TB] FAIL reset addrs: got rf=%0d dmem=%h, want rf=0 dmem=%h", rfAddr, dmemAddr, BASE);
    end
    @(negedge clk);
    halt = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_full_dump();
    preload_pattern();
    do_reset();
    stream_dump(0, 1'b1, -1, "full");
  endtask

  task automatic test_backpressure();
    preload_pattern();
    do_reset();
    stream_dump(1, 1'b1, -1, "backpressure");
  endtask

  task automatic test_halt_glitch();
    preload_pattern();
    do_reset();
    stream_dump(0, 1'b0, -1, "halt_glitch");
    for (int i = 0; i < 4; i++) begin
      halt = 1'(i % 2);
      @(negedge clk);
      nAssert++;
      if (done !== 1'b1 || outValid !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL done_sticky cycle %0d: got done=%b valid=%b, want done=1 valid=0", i, done, outValid);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    preload_pattern();
    do_reset();
    stream_dump(0, 1'b1, 10, "mid_pre");
    #2 rst = 1'b1;
    #1;
    nAssert++;
    if (outValid !== 1'b0 || outData !== 32'h0 || checksum !== 32'h0 || outIndex !== 32'h0) begin
      nFail++;
      $display("[TB] FAIL mid_reset: got valid=%b data=%h idx=%0d sum=%h, want 0 0 0 0", outValid, outData, outIndex, checksum);
    end
    @(negedge clk);
    rst = 1'b0;
    stream_dump(0, 1'b1, -1, "mid_restart");
  endtask

  task automatic test_checksum_wrap();
    int          cnt = 0;
    int          lastCnt = 0;
    logic [31:0] obsSum = 32'h0;
    logic [31:0] wantSum = 32'h0;
    // x0 contributes zero, the remaining seven words are all ones.
    for (int i = 1; i < 8; i++) wantSum += 32'hFFFF_FFFF;
    do_reset();
    sHalt = 1'b1;
    sReady = 1'b1;
    for (int c = 0; c < 30 && sDone !== 1'b1; c++) begin
      @(negedge clk);
      if (sValid === 1'b1) begin
        nAssert++;
        if (sIndex !== 32'(cnt % 4) || sIsMem !== (cnt >= 4)) begin
          nFail++;
          $display("[TB] FAIL wrap beat %0d: got idx=%0d mem=%b, want idx=%0d mem=%b", cnt, sIndex, sIsMem, cnt % 4, cnt >= 4);
        end
        obsSum += sData;
        if (sLast === 1'b1) lastCnt++;
        cnt++;
      end
    end
    nAssert++;
    if (sDone !== 1'b1 || cnt != 8 || lastCnt != 1) begin
      nFail++;
      $display("[TB] FAIL wrap count: got done=%b beats=%0d lasts=%0d, want done=1 beats=8 lasts=1", sDone, cnt, lastCnt);
    end
    nAssert++;
    if (sChecksum !== wantSum || obsSum !== wantSum) begin
      nFail++;
      $display("[TB] FAIL wrap checksum: got %h (stream %h), want %h", sChecksum, obsSum, wantSum);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NREGS; i++) rfModel[i] = $urandom;
      for (int k = 0; k < NMEM; k++) memModel[k] = $urandom;
      build_model();
      do_reset();
      stream_dump(2, 1'b1, -1, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) rfModel[i] = 32'h0;
    for (int k = 0; k < NMEM; k++) memModel[k] = 32'h0;
    #2;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_checksum_wrap();
    test_halt_glitch();
    test_reset_mid_dump();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/state_dump_unit.md
# state_dump_unit

Post-halt readout engine for the pipelined CPU. Once the CPU asserts `halt`, it reads the register file and then data memory through dedicated read-only ports and streams every word out over a valid/ready interface. It is the hardware counterpart of the bench's end-of-run register and memory dumps, and lets silicon or FPGA runs export final architectural state without simulator memory access. It sits beside the CPU, sharing the RF and DMEM read ports that are idle after halt.

## Interface
- `NUM_REGS`, 32: register-file entries dumped, indices 0..NUM_REGS-1.
- `MEM_WORDS`, 1024: 32-bit DMEM words dumped.
- `MEM_BASE`, 32'h0000_0000: byte address of the first DMEM word dumped.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; forces IDLE and the reset values below.
- `halt`  in  1  CPU halt; level, sampled only in IDLE.
- `rf_raddr`  out  5  RF read address; the read is combinational.
- `rf_rdata`  in  32  RF read data, valid in the same cycle.
- `dmem_raddr`  out  32  DMEM byte address, word-aligned; the read is combinational.
- `dmem_rdata`  in  32  DMEM read data, valid in the same cycle.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  32  dumped word.
- `out_is_mem`  out  1  0 = register beat, 1 = memory beat.
- `out_index`  out  32  register index or word index of the beat.
- `out_last`  out  1  high on the final beat only.
- `done`  out  1  dump complete; stays high until reset.
- `checksum`  out  32  mod-2^32 sum of all accepted beats.

## Operation
- FSM states are IDLE, REGS, MEM and DONE.
- **IDLE**
  - `out_valid` is 0.
  - On an edge with `halt`=1: load word 0 (register x0) into the output register, set `out_valid`=1, and go to REGS.
- **Fetch pointer**
  - `fptr` is the next word to fetch. It drives `rf_raddr` in REGS and `dmem_raddr` = MEM_BASE + 4·fptr in MEM.
  - The output register reloads from the selected read data when `out_valid && out_ready`.
  - The fetch pointer advances on the same edge.
- **REGS**
  - Register x0 is always emitted as 0, whatever `rf_rdata` is.
  - After beat NUM_REGS-1 is accepted, the next load is memory word 0 and the FSM goes to MEM. The switch costs no bubble.
- **MEM**
  - After the handshake on word MEM_WORDS-1, `out_valid` drops and the FSM goes to DONE.
  - `out_last`=1 on that final beat.
- **DONE**
  - `done`=1, `out_valid`=0.
  - Further `halt` changes are ignored. Only `rst` exits DONE.
- **Halt handling**
  - `halt` falling after the dump has started is ignored. The dump always completes.
- **Checksum**
  - `checksum` += `out_data` on every handshake, with 32-bit wraparound.
  - The final value is valid when `done`=1.
- **Backpressure**
  - While `out_valid && !out_ready`, `out_data`, `out_index`, `out_is_mem` and `out_last` hold stable.
  - `out_valid` never deasserts without a handshake.
- **Reset values**
  - Outputs: `out_valid`=0, `out_data`=0, `out_is_mem`=0, `out_index`=0, `out_last`=0, `done`=0, `checksum`=0, `rf_raddr`=0, `dmem_raddr`=MEM_BASE.
  - Internal: `fptr`=0.
- **Reset mid-dump:** asynchronous abort to IDLE. A fresh dump restarts from register 0 if `halt` is still high.

## Timing
- Halt seen at edge N: first beat valid after edge N; the first possible handshake is at edge N+1.
- Throughput is 1 beat/cycle with `out_ready` held high.
- Total beats = NUM_REGS + MEM_WORDS.
- With `out_ready` always 1, `done` rises at edge N + NUM_REGS + MEM_WORDS.
- Each zero-ready cycle adds exactly one cycle of latency.

## Structure
- A shared package holds:
  - the state encoding `dump_state_t` (IDLE=0, REGS=1, MEM=2, DONE=3);
  - `WORD_W`=32 and `RF_AW`=5.
- The FSM, fetch pointer and output register are one module.
- The 32-bit accumulator is a natural sub-module, `dump_checksum`, with inputs clear, enable and data.

## Test plan
- **Reset:** assert `rst` mid-cycle with no clock edge -> all outputs at their reset values immediately.
- **Full dump:** registers preloaded with xN = N·0x11, DMEM word k = 0xA000_0000 + k, NUM_REGS=32, MEM_WORDS=8, `out_ready`=1, raise `halt`.
  - Expect 40 beats in 40 consecutive cycles.
  - Beat 0 is 0 even though x0 is preloaded with 0xDEAD_BEEF.
  - Beat 32 is 0xA000_0000 with `out_is_mem`=1 and `out_index`=0.
  - `out_last` is on beat 39 only.
  - `done` rises the following cycle.
- **Backpressure:** same preload; drive `out_ready` as 1,0,0,1 repeating.
  - Data holds stable during the 0 cycles.
  - No beat is lost or duplicated.
  - `checksum` matches the full-dump run exactly.
- **Checksum wrap:** all words 0xFFFF_FFFF with 4 registers and 4 memory words -> `checksum` = 0xFFFF_FFF9 (x0 contributes 0).
- **Halt glitch:** `halt` high for one cycle, then low -> the full dump still completes and `done`=1.
- **Reset mid-dump:** assert `rst` at beat 10 with `halt` held high.
  - Outputs clear asynchronously.
  - After release, the dump restarts at register 0 and `checksum` restarts from 0.
